// File: rtl/frame_sequencer_pkg.sv
// Shared constants for the frame sequencer: state encoding, map grid and player state widths.
// Pure definitions, no logic; the saturating helper is combinational.
package frame_sequencer_pkg;

   localparam int GRID_X_W = 6;
   localparam int GRID_Y_W = 5;
   localparam int POS_X_W  = 14;
   localparam int POS_Y_W  = 13;
   localparam int ANGLE_W  = 8;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_UPDATE = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;
   localparam logic [1:0] ST_RENDER = 2'd3;

   // Adds up to two events to an 8-bit counter, pinning at 8'hFF.
   function automatic logic [7:0] sat_add8(input logic [7:0] base, input logic [1:0] inc);
      logic [8:0] sum;
      sum = {1'b0, base} + {7'd0, inc};
      return sum[8] ? 8'hFF : sum[7:0];
   endfunction

endpackage

// File: rtl/frame_sequencer_grid_port_mux.sv
// Selects which client drives the shared map ROM address: updater during UPDATE, renderer otherwise.
// Purely combinational, zero latency, no flow control.
module grid_port_mux
   import frame_sequencer_pkg::*;
(
   input  logic                sel_upd,
   input  logic [GRID_X_W-1:0] upd_grid_x,
   input  logic [GRID_Y_W-1:0] upd_grid_y,
   input  logic [GRID_X_W-1:0] rnd_grid_x,
   input  logic [GRID_Y_W-1:0] rnd_grid_y,
   output logic [GRID_X_W-1:0] grid_x,
   output logic [GRID_Y_W-1:0] grid_y
);

   assign grid_x = sel_upd ? upd_grid_x : rnd_grid_x;
   assign grid_y = sel_upd ? upd_grid_y : rnd_grid_y;

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame sequencer: IDLE -> UPDATE -> COMMIT -> RENDER, one queued tick, saturating overrun count.
// Start pulses lag the state change by zero cycles; FRAME_TIMEOUT_EN adds a per-phase watchdog.
module frame_sequencer
   import frame_sequencer_pkg::*;
#(
   parameter logic [13:0] SPAWN_X        = 14'd1600,
   parameter logic [12:0] SPAWN_Y        = 13'd1600,
   parameter logic [7:0]  SPAWN_ANGLE    = 8'd0,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd2000000
)
(
   input  logic        clock,
   input  logic        reset,
   input  logic        frame_tick,
   output logic        upd_start,
   input  logic        upd_done,
   input  logic [13:0] upd_next_x,
   input  logic [12:0] upd_next_y,
   input  logic [7:0]  upd_next_angle,
   input  logic [5:0]  upd_grid_x,
   input  logic [4:0]  upd_grid_y,
   output logic        rnd_start,
   input  logic        rnd_done,
   input  logic [5:0]  rnd_grid_x,
   input  logic [4:0]  rnd_grid_y,
   output logic [5:0]  grid_x,
   output logic [4:0]  grid_y,
   output logic [13:0] cur_pos_x,
   output logic [12:0] cur_pos_y,
   output logic [7:0]  cur_angle,
   output logic        busy,
   output logic [7:0]  overrun_count
);

   logic [1:0] state;
   logic [1:0] next_state;
   logic       tick_pending;
   logic       phase_tmo;
   logic       render_exit;
   logic       tick_overrun;

`ifdef FRAME_TIMEOUT_EN
   logic [31:0] phase_cnt;
   logic        in_phase;

   assign in_phase  = (state == ST_UPDATE) || (state == ST_RENDER);
   assign phase_tmo = in_phase && (phase_cnt == TIMEOUT_CYCLES - 32'd1);

   always_ff @(posedge clock) begin
      if (reset)
         phase_cnt <= 32'd0;
      else if ((next_state != state) && ((next_state == ST_UPDATE) || (next_state == ST_RENDER)))
         phase_cnt <= 32'd0;
      else if (in_phase)
         phase_cnt <= phase_cnt + 32'd1;
   end
`else
   assign phase_tmo = 1'b0;
`endif

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:   if (frame_tick || tick_pending) next_state = ST_UPDATE;
         ST_UPDATE: begin
            if (upd_done)       next_state = ST_COMMIT;
            else if (phase_tmo) next_state = ST_RENDER;
         end
         ST_COMMIT: next_state = ST_RENDER;
         ST_RENDER: if (rnd_done || phase_tmo) next_state = ST_IDLE;
         default:   next_state = ST_IDLE;
      endcase
   end

   assign busy        = (state != ST_IDLE);
   assign render_exit = (state == ST_RENDER) && (rnd_done || phase_tmo);
   // A tick landing on the render exit just queues the next frame; it never counts as dropped.
   assign tick_overrun = busy && frame_tick && tick_pending && !render_exit;

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= ST_IDLE;
         upd_start     <= 1'b0;
         rnd_start     <= 1'b0;
         tick_pending  <= 1'b0;
         overrun_count <= 8'd0;
         cur_pos_x     <= SPAWN_X;
         cur_pos_y     <= SPAWN_Y;
         cur_angle     <= SPAWN_ANGLE;
      end else begin
         state     <= next_state;
         upd_start <= (state == ST_IDLE) && (next_state == ST_UPDATE);
         rnd_start <= (state != ST_RENDER) && (next_state == ST_RENDER);

         if (state == ST_IDLE)
            tick_pending <= 1'b0;
         else if (frame_tick)
            tick_pending <= 1'b1;

         overrun_count <= sat_add8(overrun_count, {1'b0, tick_overrun} + {1'b0, phase_tmo});

         if (state == ST_COMMIT) begin
            cur_pos_x <= upd_next_x;
            cur_pos_y <= upd_next_y;
            cur_angle <= upd_next_angle;
         end
      end
   end

   grid_port_mux u_grid_mux (
      .sel_upd    (state == ST_UPDATE),
      .upd_grid_x (upd_grid_x),
      .upd_grid_y (upd_grid_y),
      .rnd_grid_x (rnd_grid_x),
      .rnd_grid_y (rnd_grid_y),
      .grid_x     (grid_x),
      .grid_y     (grid_y)
   );

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer; the watchdog section runs only with FRAME_TIMEOUT_EN defined.
module tb_frame_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic        frame_tick;
   logic        upd_start;
   logic        upd_done;
   logic [13:0] upd_next_x;
   logic [12:0] upd_next_y;
   logic [7:0]  upd_next_angle;
   logic [5:0]  upd_grid_x;
   logic [4:0]  upd_grid_y;
   logic        rnd_start;
   logic        rnd_done;
   logic [5:0]  rnd_grid_x;
   logic [4:0]  rnd_grid_y;
   logic [5:0]  grid_x;
   logic [4:0]  grid_y;
   logic [13:0] cur_pos_x;
   logic [12:0] cur_pos_y;
   logic [7:0]  cur_angle;
   logic        busy;
   logic [7:0]  overrun_count;

   int vectors = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   frame_sequencer #(
      .SPAWN_X        (14'd1600),
      .SPAWN_Y        (13'd1600),
      .SPAWN_ANGLE    (8'd0),
      .TIMEOUT_CYCLES (32'd16)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .frame_tick     (frame_tick),
      .upd_start      (upd_start),
      .upd_done       (upd_done),
      .upd_next_x     (upd_next_x),
      .upd_next_y     (upd_next_y),
      .upd_next_angle (upd_next_angle),
      .upd_grid_x     (upd_grid_x),
      .upd_grid_y     (upd_grid_y),
      .rnd_start      (rnd_start),
      .rnd_done       (rnd_done),
      .rnd_grid_x     (rnd_grid_x),
      .rnd_grid_y     (rnd_grid_y),
      .grid_x         (grid_x),
      .grid_y         (grid_y),
      .cur_pos_x      (cur_pos_x),
      .cur_pos_y      (cur_pos_y),
      .cur_angle      (cur_angle),
      .busy           (busy),
      .overrun_count  (overrun_count)
   );

   // Outputs are sampled and inputs changed 1 ns after each rising edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic chk_cur(input string tag, input int x, input int y, input int a);
      chk({tag, "_x"}, 32'(cur_pos_x), 32'(x));
      chk({tag, "_y"}, 32'(cur_pos_y), 32'(y));
      chk({tag, "_ang"}, 32'(cur_angle), 32'(a));
   endtask

   initial begin
      reset = 1'b1;
      frame_tick = 1'b0;
      upd_done = 1'b0;
      rnd_done = 1'b0;
      upd_next_x = 14'd1700;
      upd_next_y = 13'd1600;
      upd_next_angle = 8'd5;
      upd_grid_x = 6'd3;
      upd_grid_y = 5'd4;
      rnd_grid_x = 6'd9;
      rnd_grid_y = 5'd9;
      step();
      step();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ovr", 32'(overrun_count), 0);
      reset = 1'b0;

      // Idle for 10 cycles: nothing moves, no start pulses.
      for (int i = 0; i < 10; i++) begin
         step();
         chk("idle_busy", 32'(busy), 0);
         chk("idle_upd_start", 32'(upd_start), 0);
         chk("idle_rnd_start", 32'(rnd_start), 0);
      end
      chk_cur("idle_cur", 1600, 1600, 0);
      chk("idle_grid_x", 32'(grid_x), 9);

      // One frame: tick, updater done in its 5th cycle.
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      chk("upd_busy", 32'(busy), 1);
      chk("upd_start_pulse", 32'(upd_start), 1);
      chk("upd_grid_x", 32'(grid_x), 3);
      chk("upd_grid_y", 32'(grid_y), 4);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("upd_start_low", 32'(upd_start), 0);
         chk("upd_rnd_start_low", 32'(rnd_start), 0);
      end
      upd_done = 1'b1;
      step();
      upd_done = 1'b0;
      chk("commit_grid_x", 32'(grid_x), 9);
      chk("commit_rnd_start", 32'(rnd_start), 0);
      chk_cur("commit_old", 1600, 1600, 0);
      step();
      chk("rnd_start_pulse", 32'(rnd_start), 1);
      chk_cur("commit_new", 1700, 1600, 5);
      chk("rnd_grid_x", 32'(grid_x), 9);
      chk("rnd_grid_y", 32'(grid_y), 9);
      upd_done = 1'b1;
      upd_next_x = 14'd1;
      step();
      upd_done = 1'b0;
      chk("rnd_start_low", 32'(rnd_start), 0);
      chk_cur("render_hold", 1700, 1600, 5);

      // Three ticks during one RENDER: first queues, the other two overrun.
      for (int i = 0; i < 3; i++) begin
         frame_tick = 1'b1;
         step();
         frame_tick = 1'b0;
         step();
      end
      chk("ovr_three_ticks", 32'(overrun_count), 2);
      chk("ovr_still_busy", 32'(busy), 1);
      rnd_done = 1'b1;
      step();
      rnd_done = 1'b0;
      chk("queued_idle", 32'(busy), 0);
      step();
      chk("queued_upd_start", 32'(upd_start), 1);
      chk("queued_busy", 32'(busy), 1);
      chk("queued_ovr", 32'(overrun_count), 2);

      // Wide values are copied verbatim.
      upd_next_x = 14'h3FFF;
      upd_next_y = 13'h1FFF;
      upd_next_angle = 8'hFF;
      upd_done = 1'b1;
      step();
      upd_done = 1'b0;
      step();
      chk_cur("wide_commit", 16383, 8191, 255);

      // Tick coinciding with the render exit starts the next frame, no overrun.
      rnd_done = 1'b1;
      frame_tick = 1'b1;
      step();
      rnd_done = 1'b0;
      frame_tick = 1'b0;
      chk("exit_tick_idle", 32'(busy), 0);
      chk("exit_tick_ovr", 32'(overrun_count), 2);
      step();
      chk("exit_tick_upd_start", 32'(upd_start), 1);
      upd_done = 1'b1;
      step();
      upd_done = 1'b0;
      step();
      chk("second_render_start", 32'(rnd_start), 1);

      // Reset in RENDER; a late rnd_done afterwards must not move anything.
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_ovr", 32'(overrun_count), 0);
      chk("midrst_rnd_start", 32'(rnd_start), 0);
      chk_cur("midrst_spawn", 1600, 1600, 0);
      rnd_done = 1'b1;
      upd_done = 1'b1;
      step();
      rnd_done = 1'b0;
      upd_done = 1'b0;
      chk("late_done_busy", 32'(busy), 0);
      chk("late_done_upd_start", 32'(upd_start), 0);
      step();
      chk("late_done_busy2", 32'(busy), 0);

`ifdef FRAME_TIMEOUT_EN
      // Updater never answers: watchdog jumps to RENDER after 16 UPDATE cycles.
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      chk("tmo_upd_start", 32'(upd_start), 1);
      for (int i = 0; i < 15; i++) begin
         step();
         chk("tmo_wait_rnd_start", 32'(rnd_start), 0);
      end
      step();
      chk("tmo_rnd_start", 32'(rnd_start), 1);
      chk("tmo_ovr", 32'(overrun_count), 1);
      chk("tmo_grid_x", 32'(grid_x), 9);
      chk_cur("tmo_cur", 1600, 1600, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
